// File: rtl/aes_core_seq.sv
// aes_core_seq: initiator-side sequencer for the AES core init/next handshake.
// Accepts one block request at a time, reuses the expanded key when the
// request key matches the cached one, runs the block and returns the result
// (or a timeout error) on a valid/ready response port. All outputs are flops.
module aes_core_seq #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic         ICLK,
  input  logic         IRST,
  input  logic         IREQ_VALID,
  output logic         OREQ_READY,
  input  logic [255:0] IREQ_KEY,
  input  logic         IREQ_KEYLEN,
  input  logic         IREQ_ENCDEC,
  input  logic [127:0] IREQ_BLOCK,
  input  logic         IKEY_FLUSH,
  output logic         ORSP_VALID,
  input  logic         IRSP_READY,
  output logic [127:0] ORSP_DATA,
  output logic         ORSP_ERR,
  output logic         OCORE_ENCDEC,
  output logic         OCORE_KEYLEN,
  output logic [255:0] OCORE_KEY,
  output logic [127:0] OCORE_BLOCK,
  output logic         OCORE_INIT,
  output logic         OCORE_NEXT,
  input  logic         ICORE_READY,
  input  logic [127:0] ICORE_RESULT
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // Last wait count before giving up; the guard cycle counts toward the limit.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_GUARD_I,
    S_WAIT_I,
    S_NEXT,
    S_GUARD_N,
    S_WAIT_N,
    S_RESP
  } state_t;

  state_t           state_q,       state_d;
  logic [CNT_W-1:0] cnt_q,         cnt_d;
  logic             req_rdy_q,     req_rdy_d;
  logic             rsp_vld_q,     rsp_vld_d;
  logic [127:0]     rsp_data_q,    rsp_data_d;
  logic             rsp_err_q,     rsp_err_d;
  logic             core_encdec_q, core_encdec_d;
  logic             core_keylen_q, core_keylen_d;
  logic [255:0]     core_key_q,    core_key_d;
  logic [127:0]     core_block_q,  core_block_d;
  logic             core_init_q,   core_init_d;
  logic             core_next_q,   core_next_d;
  logic             cache_vld_q,   cache_vld_d;
  logic [255:0]     cache_key_q,   cache_key_d;
  logic             cache_keylen_q, cache_keylen_d;
  logic             flushed_q,     flushed_d;

  // AES-128 keys live in the upper half; the lower half is don't-care.
  function automatic logic key_match(input logic [255:0] a,
                                     input logic [255:0] b,
                                     input logic         keylen);
    if (keylen) key_match = (a == b);
    else        key_match = (a[255:128] == b[255:128]);
  endfunction

  // Next-state, datapath capture, cache bookkeeping and registered outputs.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    rsp_data_d     = rsp_data_q;
    rsp_err_d      = rsp_err_q;
    core_encdec_d  = core_encdec_q;
    core_keylen_d  = core_keylen_q;
    core_key_d     = core_key_q;
    core_block_d   = core_block_q;
    cache_vld_d    = cache_vld_q;
    cache_key_d    = cache_key_q;
    cache_keylen_d = cache_keylen_q;
    flushed_d      = flushed_q;

    case (state_q)
      S_IDLE: begin
        if (IREQ_VALID) begin
          core_key_d    = IREQ_KEY;
          core_keylen_d = IREQ_KEYLEN;
          core_encdec_d = IREQ_ENCDEC;
          core_block_d  = IREQ_BLOCK;
          flushed_d     = 1'b0;
          // A flush in the accept cycle forces a fresh key expansion.
          if (cache_vld_q && !IKEY_FLUSH && (IREQ_KEYLEN == cache_keylen_q) &&
              key_match(IREQ_KEY, cache_key_q, IREQ_KEYLEN))
            state_d = S_NEXT;
          else
            state_d = S_INIT;
        end
      end
      S_INIT: begin
        cnt_d   = '0;
        state_d = S_GUARD_I;
      end
      S_GUARD_I: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = S_WAIT_I;
      end
      S_WAIT_I: begin
        cnt_d = cnt_q + 1'b1;
        if (ICORE_READY) begin
          // A flush seen during expansion keeps the new key uncached.
          cache_vld_d    = ~flushed_q;
          cache_key_d    = core_key_q;
          cache_keylen_d = core_keylen_q;
          state_d        = S_NEXT;
        end else if (cnt_q >= CNT_LAST) begin
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          cache_vld_d = 1'b0;
          state_d     = S_RESP;
        end
      end
      S_NEXT: begin
        cnt_d   = '0;
        state_d = S_GUARD_N;
      end
      S_GUARD_N: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = S_WAIT_N;
      end
      S_WAIT_N: begin
        cnt_d = cnt_q + 1'b1;
        if (ICORE_READY) begin
          rsp_data_d = ICORE_RESULT;
          rsp_err_d  = 1'b0;
          state_d    = S_RESP;
        end else if (cnt_q >= CNT_LAST) begin
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          cache_vld_d = 1'b0;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (IRSP_READY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Flush wins over any cache fill in the same cycle.
    if (IKEY_FLUSH) begin
      cache_vld_d = 1'b0;
      if (state_q == S_INIT || state_q == S_GUARD_I || state_q == S_WAIT_I)
        flushed_d = 1'b1;
    end

    // Outputs are registered copies of the state being entered.
    req_rdy_d   = (state_d == S_IDLE);
    rsp_vld_d   = (state_d == S_RESP);
    core_init_d = (state_d == S_INIT);
    core_next_d = (state_d == S_NEXT);
  end

  // State and output registers; reset returns everything to zero/IDLE.
  always_ff @(posedge ICLK or posedge IRST) begin
    if (IRST) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      req_rdy_q      <= 1'b0;
      rsp_vld_q      <= 1'b0;
      rsp_data_q     <= '0;
      rsp_err_q      <= 1'b0;
      core_encdec_q  <= 1'b0;
      core_keylen_q  <= 1'b0;
      core_key_q     <= '0;
      core_block_q   <= '0;
      core_init_q    <= 1'b0;
      core_next_q    <= 1'b0;
      cache_vld_q    <= 1'b0;
      cache_key_q    <= '0;
      cache_keylen_q <= 1'b0;
      flushed_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      req_rdy_q      <= req_rdy_d;
      rsp_vld_q      <= rsp_vld_d;
      rsp_data_q     <= rsp_data_d;
      rsp_err_q      <= rsp_err_d;
      core_encdec_q  <= core_encdec_d;
      core_keylen_q  <= core_keylen_d;
      core_key_q     <= core_key_d;
      core_block_q   <= core_block_d;
      core_init_q    <= core_init_d;
      core_next_q    <= core_next_d;
      cache_vld_q    <= cache_vld_d;
      cache_key_q    <= cache_key_d;
      cache_keylen_q <= cache_keylen_d;
      flushed_q      <= flushed_d;
    end
  end

  assign OREQ_READY   = req_rdy_q;
  assign ORSP_VALID   = rsp_vld_q;
  assign ORSP_DATA    = rsp_data_q;
  assign ORSP_ERR     = rsp_err_q;
  assign OCORE_ENCDEC = core_encdec_q;
  assign OCORE_KEYLEN = core_keylen_q;
  assign OCORE_KEY    = core_key_q;
  assign OCORE_BLOCK  = core_block_q;
  assign OCORE_INIT   = core_init_q;
  assign OCORE_NEXT   = core_next_q;

endmodule

// File: tb/tb_aes_core_seq.sv
// Bench for aes_core_seq: behavioural AES core model driven by a small table
// of known-answer vectors, a scoreboard queue of expected responses, and a
// monitor that pops and compares on every response handshake.
module tb_aes_core_seq;

  localparam int TMO = 16;

  localparam logic [255:0] K128  = 256'h000102030405060708090a0b0c0d0e0f_00000000000000000000000000000000;
  localparam logic [255:0] K128J = 256'h000102030405060708090a0b0c0d0e0f_deadbeefcafef00d0123456789abcdef;
  localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         ICLK = 1'b0;
  logic         IRST = 1'b1;
  logic         IREQ_VALID = 1'b0;
  logic         OREQ_READY;
  logic [255:0] IREQ_KEY = '0;
  logic         IREQ_KEYLEN = 1'b0;
  logic         IREQ_ENCDEC = 1'b0;
  logic [127:0] IREQ_BLOCK = '0;
  logic         IKEY_FLUSH = 1'b0;
  logic         ORSP_VALID;
  logic         IRSP_READY = 1'b1;
  logic [127:0] ORSP_DATA;
  logic         ORSP_ERR;
  logic         OCORE_ENCDEC, OCORE_KEYLEN;
  logic [255:0] OCORE_KEY;
  logic [127:0] OCORE_BLOCK;
  logic         OCORE_INIT, OCORE_NEXT;
  logic         ICORE_READY = 1'b1;
  logic [127:0] ICORE_RESULT = '0;

  aes_core_seq #(.TIMEOUT_CYCLES(TMO)) dut (
    .ICLK(ICLK), .IRST(IRST),
    .IREQ_VALID(IREQ_VALID), .OREQ_READY(OREQ_READY),
    .IREQ_KEY(IREQ_KEY), .IREQ_KEYLEN(IREQ_KEYLEN), .IREQ_ENCDEC(IREQ_ENCDEC),
    .IREQ_BLOCK(IREQ_BLOCK), .IKEY_FLUSH(IKEY_FLUSH),
    .ORSP_VALID(ORSP_VALID), .IRSP_READY(IRSP_READY),
    .ORSP_DATA(ORSP_DATA), .ORSP_ERR(ORSP_ERR),
    .OCORE_ENCDEC(OCORE_ENCDEC), .OCORE_KEYLEN(OCORE_KEYLEN),
    .OCORE_KEY(OCORE_KEY), .OCORE_BLOCK(OCORE_BLOCK),
    .OCORE_INIT(OCORE_INIT), .OCORE_NEXT(OCORE_NEXT),
    .ICORE_READY(ICORE_READY), .ICORE_RESULT(ICORE_RESULT)
  );

  always #5 ICLK = ~ICLK;

  typedef struct packed {
    logic [127:0] data;
    logic         err;
  } rsp_t;

  rsp_t sbq[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   inits = 0;
  int   nexts = 0;
  int   core_dly = 2;
  bit   stall_next = 1'b0;
  bit   stalled = 1'b0;
  int   model_cnt = 0;
  int   first_vld_cyc = 0;
  int   acc_cyc = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Known-answer table standing in for the real cipher.
  function automatic logic [127:0] core_fn(input logic [255:0] key, input logic kl,
                                           input logic ed, input logic [127:0] blk);
    logic [127:0] up;
    up = key[255:128];
    if (!kl && up == K128[255:128] && ed && blk == PT) return CT128;
    if (!kl && up == K128[255:128] && !ed && blk == CT128) return PT;
    if (kl && key == K256 && ed && blk == PT) return CT256;
    if (kl && key == K256 && !ed && blk == CT256) return PT;
    return ~blk ^ up;
  endfunction

  initial forever begin
    @(posedge ICLK);
    cyc++;
  end

  // Core model: drops ready after each command, raises it core_dly cycles later.
  initial forever begin
    @(negedge ICLK);
    if (IRST) begin
      ICORE_READY = 1'b1;
      model_cnt = 0;
      stalled = 1'b0;
    end else if (OCORE_INIT) begin
      inits++;
      ICORE_READY = 1'b0;
      model_cnt = core_dly;
      stalled = 1'b0;
    end else if (OCORE_NEXT) begin
      nexts++;
      ICORE_READY = 1'b0;
      model_cnt = core_dly;
      stalled = stall_next;
      ICORE_RESULT = core_fn(OCORE_KEY, OCORE_KEYLEN, OCORE_ENCDEC, OCORE_BLOCK);
    end else if (model_cnt > 0) begin
      model_cnt--;
      if (model_cnt == 0 && !stalled) ICORE_READY = 1'b1;
    end
  end

  // Monitor: compares each handshaken response against the scoreboard head.
  initial begin
    rsp_t e;
    bit   prev = 1'b0;
    forever begin
      @(negedge ICLK);
      if (ORSP_VALID && !prev) first_vld_cyc = cyc;
      prev = ORSP_VALID;
      if (ORSP_VALID && IRSP_READY && !IRST) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rsp_unexpected: got data %0h err %0b with empty scoreboard", ORSP_DATA, ORSP_ERR);
        end else begin
          e = sbq.pop_front();
          chk("rsp_data", ORSP_DATA, e.data);
          chk("rsp_err", ORSP_ERR, e.err);
        end
      end
    end
  end

  task automatic send(input logic [255:0] key, input logic kl, input logic ed,
                      input logic [127:0] blk, input logic fl,
                      input logic [127:0] exp_data, input logic exp_err);
    int n = 0;
    sbq.push_back('{exp_data, exp_err});
    @(posedge ICLK); #1;
    IREQ_KEY = key; IREQ_KEYLEN = kl; IREQ_ENCDEC = ed; IREQ_BLOCK = blk;
    IKEY_FLUSH = fl; IREQ_VALID = 1'b1;
    @(negedge ICLK);
    while (!OREQ_READY && n < 100) begin
      @(negedge ICLK);
      n++;
    end
    chk("req_accept", OREQ_READY, 1'b1);
    acc_cyc = cyc;
    @(posedge ICLK); #1;
    IREQ_VALID = 1'b0; IKEY_FLUSH = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sbq.size() != 0 && n < 400) begin
      @(negedge ICLK);
      n++;
    end
    chk("rsp_wait", sbq.size(), 0);
  endtask

  task automatic run(input string tag, input logic [255:0] key, input logic kl,
                     input logic ed, input logic [127:0] blk, input logic fl,
                     input logic [127:0] exp_data, input logic exp_err,
                     input int exp_init, input int exp_lat);
    int i0, n0;
    i0 = inits; n0 = nexts;
    send(key, kl, ed, blk, fl, exp_data, exp_err);
    wait_done();
    chk({tag, "_init"}, inits - i0, exp_init);
    chk({tag, "_next"}, nexts - n0, 1);
    if (exp_lat >= 0) chk({tag, "_lat"}, first_vld_cyc - acc_cyc, exp_lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int i0, n0, n, lat;

    // Reset state
    repeat (3) @(negedge ICLK);
    chk("rst_req_ready", OREQ_READY, 1'b0);
    chk("rst_rsp_valid", ORSP_VALID, 1'b0);
    chk("rst_rsp_data", ORSP_DATA, 128'h0);
    chk("rst_core_pulses", {OCORE_INIT, OCORE_NEXT}, 2'b00);
    chk("rst_core_key", OCORE_KEY, 256'h0);
    @(posedge ICLK); #1;
    IRST = 1'b0;
    @(posedge ICLK);
    @(negedge ICLK);
    chk("post_rst_ready", OREQ_READY, 1'b1);

    // Cold AES-128 encrypt, then hit with junk in the ignored lower key half
    run("a128_cold", K128, 1'b0, 1'b1, PT, 1'b0, CT128, 1'b0, 1, 7);
    run("a128_hit_dec", K128J, 1'b0, 1'b0, CT128, 1'b0, PT, 1'b0, 0, 4);

    // AES-256 miss, flush on accept forces INIT, then a plain hit
    run("a256_miss", K256, 1'b1, 1'b1, PT, 1'b0, CT256, 1'b0, 1, 7);
    run("a256_flush_acc", K256, 1'b1, 1'b1, PT, 1'b1, CT256, 1'b0, 1, 7);
    run("a256_hit", K256, 1'b1, 1'b1, PT, 1'b0, CT256, 1'b0, 0, 4);

    // Same upper bits but 128-bit length: keylen mismatch is a miss
    run("keylen_miss", K256, 1'b0, 1'b1, PT, 1'b0, CT128, 1'b0, 1, 7);

    // Flush while waiting for key expansion: key must not become cached
    core_dly = 6;
    i0 = inits;
    send(K256, 1'b1, 1'b1, PT, 1'b0, CT256, 1'b0);
    @(posedge ICLK); #1;
    @(posedge ICLK); #1;
    IKEY_FLUSH = 1'b1;
    @(posedge ICLK); #1;
    IKEY_FLUSH = 1'b0;
    wait_done();
    chk("flush_wait_i_init", inits - i0, 1);
    core_dly = 2;
    run("after_flush_wait_i", K256, 1'b1, 1'b1, PT, 1'b0, CT256, 1'b0, 1, 7);

    // Timeout: core never completes the block
    stall_next = 1'b1;
    run("timeout", K256, 1'b1, 1'b1, PT, 1'b0, 128'h0, 1'b1, 0, -1);
    lat = first_vld_cyc - acc_cyc;
    chk("timeout_lat_window", (lat >= TMO && lat <= TMO + 4), 1'b1);
    stall_next = 1'b0;
    run("after_timeout", K256, 1'b1, 1'b1, PT, 1'b0, CT256, 1'b0, 1, 7);

    // Backpressure with a second request waiting
    i0 = inits;
    @(posedge ICLK); #1;
    IRSP_READY = 1'b0;
    send(K256, 1'b1, 1'b1, PT, 1'b0, CT256, 1'b0);
    n = 0;
    @(negedge ICLK);
    while (!ORSP_VALID && n < 100) begin
      @(negedge ICLK);
      n++;
    end
    chk("bp_valid", ORSP_VALID, 1'b1);
    @(posedge ICLK); #1;
    IREQ_KEY = K256; IREQ_KEYLEN = 1'b1; IREQ_ENCDEC = 1'b0; IREQ_BLOCK = CT256;
    IREQ_VALID = 1'b1;
    sbq.push_back('{PT, 1'b0});
    for (int i = 0; i < 10; i++) begin
      @(negedge ICLK);
      chk("bp_hold_valid", ORSP_VALID, 1'b1);
      chk("bp_hold_data", ORSP_DATA, CT256);
      chk("bp_no_accept", OREQ_READY, 1'b0);
    end
    @(posedge ICLK); #1;
    IRSP_READY = 1'b1;
    @(negedge ICLK);
    @(negedge ICLK);
    chk("bp_ready_after_hs", OREQ_READY, 1'b1);
    acc_cyc = cyc;
    @(posedge ICLK); #1;
    IREQ_VALID = 1'b0;
    @(negedge ICLK);
    chk("bp_accepted", OREQ_READY, 1'b0);
    chk("bp_next_pulse", OCORE_NEXT, 1'b1);
    wait_done();
    chk("bp_init", inits - i0, 0);
    chk("bp_lat", first_vld_cyc - acc_cyc, 4);

    // Reset asserted while waiting for the block result
    core_dly = 6;
    send(K256, 1'b1, 1'b1, PT, 1'b0, CT256, 1'b0);
    @(posedge ICLK); #1;
    @(posedge ICLK); #1;
    IRST = 1'b1;
    sbq.delete();
    @(negedge ICLK);
    chk("mid_rst_ready", OREQ_READY, 1'b0);
    chk("mid_rst_rsp", {ORSP_VALID, ORSP_ERR}, 2'b00);
    chk("mid_rst_rsp_data", ORSP_DATA, 128'h0);
    chk("mid_rst_core_key", OCORE_KEY, 256'h0);
    chk("mid_rst_core_block", OCORE_BLOCK, 128'h0);
    chk("mid_rst_core_ctl", {OCORE_INIT, OCORE_NEXT, OCORE_ENCDEC, OCORE_KEYLEN}, 4'b0000);
    i0 = inits; n0 = nexts;
    @(posedge ICLK); #1;
    IRST = 1'b0;
    @(posedge ICLK);
    @(negedge ICLK);
    chk("mid_rst_ready_after", OREQ_READY, 1'b1);
    repeat (6) @(negedge ICLK);
    chk("mid_rst_no_pulse", (inits - i0) + (nexts - n0), 0);
    core_dly = 2;
    run("after_mid_rst", K256, 1'b1, 1'b1, PT, 1'b0, CT256, 1'b0, 1, 7);

    repeat (3) @(negedge ICLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
